// File: rtl/pic_cmd_sequencer.sv
// ICW1..ICW4 / OCW1..OCW3 command sequencer and configuration store for an 8259-style PIC.
// Optional registered readback on dout is enabled by defining PIC_OCW_READBACK_EN.
module pic_cmd_sequencer #(
  parameter logic [7:0]  IMR_INIT = 8'h00,
  parameter int unsigned VEC_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_strobe,
  input  logic             a0,
  input  logic [7:0]       din,
  output logic             init_done,
  output logic [2:0]       seq_state,
  output logic             init_pulse,
  output logic             ltim,
  output logic             sngl,
  output logic [VEC_W-1:0] vector_base,
  output logic [7:0]       icw3,
  output logic             aeoi,
  output logic             sfnm,
  output logic [7:0]       imr,
  output logic             ocw2_pulse,
  output logic             ocw2_r,
  output logic             ocw2_sl,
  output logic             ocw2_eoi,
  output logic [2:0]       ocw2_level,
  output logic             smm,
  output logic             ris,
  output logic             poll_pulse,
  input  logic [7:0]       irr_in,
  input  logic [7:0]       isr_in,
  output logic [7:0]       dout
);

  localparam logic [2:0] StUninit = 3'b000;
  localparam logic [2:0] StWIcw2  = 3'b001;
  localparam logic [2:0] StWIcw3  = 3'b010;
  localparam logic [2:0] StWIcw4  = 3'b011;
  localparam logic [2:0] StReady  = 3'b100;

  logic [2:0]       state_q, state_d;
  logic             ic4_q, ic4_d;
  logic             ltim_q, ltim_d;
  logic             sngl_q, sngl_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [7:0]       icw3_q, icw3_d;
  logic             aeoi_q, aeoi_d;
  logic             sfnm_q, sfnm_d;
  logic [7:0]       imr_q, imr_d;
  logic             smm_q, smm_d;
  logic             ris_q, ris_d;
  logic             init_pulse_q, init_pulse_d;
  logic             ocw2_pulse_q, ocw2_pulse_d;
  logic             poll_pulse_q, poll_pulse_d;
  logic [2:0]       ocw2_hi_q, ocw2_hi_d;
  logic [2:0]       ocw2_lvl_q, ocw2_lvl_d;

  logic is_icw1, is_data, is_ocw;

  // ICW1 is recognised in any state; OCW2/OCW3 only once initialization has finished.
  assign is_icw1 = wr_strobe & ~a0 & din[4];
  assign is_data = wr_strobe & a0;
  assign is_ocw  = wr_strobe & ~a0 & ~din[4] & (state_q == StReady);

  always_comb begin
    state_d      = state_q;
    ic4_d        = ic4_q;
    ltim_d       = ltim_q;
    sngl_d       = sngl_q;
    vec_d        = vec_q;
    icw3_d       = icw3_q;
    aeoi_d       = aeoi_q;
    sfnm_d       = sfnm_q;
    imr_d        = imr_q;
    smm_d        = smm_q;
    ris_d        = ris_q;
    ocw2_hi_d    = ocw2_hi_q;
    ocw2_lvl_d   = ocw2_lvl_q;
    init_pulse_d = 1'b0;
    ocw2_pulse_d = 1'b0;
    poll_pulse_d = 1'b0;

    if (is_icw1) begin
      ltim_d       = din[3];
      sngl_d       = din[1];
      ic4_d        = din[0];
      aeoi_d       = 1'b0;
      sfnm_d       = 1'b0;
      smm_d        = 1'b0;
      ris_d        = 1'b0;
      icw3_d       = 8'h00;
      imr_d        = IMR_INIT;
      init_pulse_d = 1'b1;
      state_d      = StWIcw2;
    end else if (is_data) begin
      case (state_q)
        StWIcw2: begin
          vec_d = din[7 -: VEC_W];
          if (!sngl_q)    state_d = StWIcw3;
          else if (ic4_q) state_d = StWIcw4;
          else            state_d = StReady;
        end
        StWIcw3: begin
          icw3_d  = din;
          state_d = ic4_q ? StWIcw4 : StReady;
        end
        StWIcw4: begin
          aeoi_d  = din[1];
          sfnm_d  = din[4];
          state_d = StReady;
        end
        StReady: imr_d = din;
        default: ;
      endcase
    end else if (is_ocw) begin
      if (!din[3]) begin
        ocw2_hi_d    = din[7:5];
        ocw2_lvl_d   = din[2:0];
        ocw2_pulse_d = 1'b1;
      end else begin
        if (din[1]) ris_d = din[0];
        if (din[6]) smm_d = din[5];
        poll_pulse_d = din[2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StUninit;
      ic4_q        <= 1'b0;
      ltim_q       <= 1'b0;
      sngl_q       <= 1'b0;
      vec_q        <= '0;
      icw3_q       <= 8'h00;
      aeoi_q       <= 1'b0;
      sfnm_q       <= 1'b0;
      imr_q        <= IMR_INIT;
      smm_q        <= 1'b0;
      ris_q        <= 1'b0;
      ocw2_hi_q    <= 3'b000;
      ocw2_lvl_q   <= 3'b000;
      init_pulse_q <= 1'b0;
      ocw2_pulse_q <= 1'b0;
      poll_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ic4_q        <= ic4_d;
      ltim_q       <= ltim_d;
      sngl_q       <= sngl_d;
      vec_q        <= vec_d;
      icw3_q       <= icw3_d;
      aeoi_q       <= aeoi_d;
      sfnm_q       <= sfnm_d;
      imr_q        <= imr_d;
      smm_q        <= smm_d;
      ris_q        <= ris_d;
      ocw2_hi_q    <= ocw2_hi_d;
      ocw2_lvl_q   <= ocw2_lvl_d;
      init_pulse_q <= init_pulse_d;
      ocw2_pulse_q <= ocw2_pulse_d;
      poll_pulse_q <= poll_pulse_d;
    end
  end

`ifdef PIC_OCW_READBACK_EN
  logic [7:0] dout_q;

  always_ff @(posedge clk) begin
    if (reset) dout_q <= 8'h00;
    else       dout_q <= a0 ? imr_q : (ris_q ? isr_in : irr_in);
  end

  assign dout = dout_q;
`else
  logic unused_readback;
  assign unused_readback = ^{irr_in, isr_in};
  assign dout            = 8'h00;
`endif

  assign init_done   = (state_q == StReady);
  assign seq_state   = state_q;
  assign init_pulse  = init_pulse_q;
  assign ltim        = ltim_q;
  assign sngl        = sngl_q;
  assign vector_base = vec_q;
  assign icw3        = icw3_q;
  assign aeoi        = aeoi_q;
  assign sfnm        = sfnm_q;
  assign imr         = imr_q;
  assign ocw2_pulse  = ocw2_pulse_q;
  assign ocw2_r      = ocw2_hi_q[2];
  assign ocw2_sl     = ocw2_hi_q[1];
  assign ocw2_eoi    = ocw2_hi_q[0];
  assign ocw2_level  = ocw2_lvl_q;
  assign smm         = smm_q;
  assign ris         = ris_q;
  assign poll_pulse  = poll_pulse_q;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed plus randomized bench for pic_cmd_sequencer, checked against a queue-based
// model of the pending initialization words.
module tb_pic_cmd_sequencer;
  localparam logic [7:0]  IMR_INIT = 8'h5A;
  localparam int unsigned VEC_W    = 5;

  logic             clk = 1'b0;
  logic             reset, wr_strobe, a0;
  logic [7:0]       din, irr_in, isr_in;
  logic             init_done, init_pulse, ltim, sngl, aeoi, sfnm;
  logic [2:0]       seq_state, ocw2_level;
  logic [VEC_W-1:0] vector_base;
  logic [7:0]       icw3, imr, dout;
  logic             ocw2_pulse, ocw2_r, ocw2_sl, ocw2_eoi, smm, ris, poll_pulse;

  pic_cmd_sequencer #(.IMR_INIT(IMR_INIT), .VEC_W(VEC_W)) dut (
    .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .a0(a0), .din(din),
    .init_done(init_done), .seq_state(seq_state), .init_pulse(init_pulse),
    .ltim(ltim), .sngl(sngl), .vector_base(vector_base), .icw3(icw3), .aeoi(aeoi),
    .sfnm(sfnm), .imr(imr), .ocw2_pulse(ocw2_pulse), .ocw2_r(ocw2_r),
    .ocw2_sl(ocw2_sl), .ocw2_eoi(ocw2_eoi), .ocw2_level(ocw2_level), .smm(smm),
    .ris(ris), .poll_pulse(poll_pulse), .irr_in(irr_in), .isr_in(isr_in), .dout(dout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: after ICW1 the list of still-expected ICW numbers is known up front.
  bit               m_init;
  int               m_pending[$];
  bit               m_ltim, m_sngl, m_ic4, m_aeoi, m_sfnm, m_smm, m_ris;
  logic [VEC_W-1:0] m_vb;
  logic [7:0]       m_icw3, m_imr, m_dout;
  bit               m_initp, m_ocw2p, m_pollp, m_r, m_sl, m_eoi;
  logic [2:0]       m_lvl;
  bit               hold_io = 1'b0;

  function automatic logic [2:0] m_state();
    if (!m_init) return 3'd0;
    if (m_pending.size() == 0) return 3'd4;
    case (m_pending[0])
      2:       return 3'd1;
      3:       return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

  task automatic model_reset();
    m_init = 0; m_pending.delete();
    m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_aeoi = 0; m_sfnm = 0; m_smm = 0; m_ris = 0;
    m_vb = '0; m_icw3 = 8'h00; m_imr = IMR_INIT; m_dout = 8'h00;
    m_initp = 0; m_ocw2p = 0; m_pollp = 0; m_r = 0; m_sl = 0; m_eoi = 0; m_lvl = 3'd0;
  endtask

  task automatic model_apply(input bit rst, input bit we, input bit ad, input logic [7:0] d);
    bit ready;
    int kind;
`ifdef PIC_OCW_READBACK_EN
    m_dout = ad ? m_imr : (m_ris ? isr_in : irr_in);
`else
    m_dout = 8'h00;
`endif
    m_initp = 0; m_ocw2p = 0; m_pollp = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!we) return;
    ready = m_init && (m_pending.size() == 0);
    if (!ad && d[4]) begin
      m_init = 1; m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
      m_aeoi = 0; m_sfnm = 0; m_smm = 0; m_ris = 0; m_icw3 = 8'h00; m_imr = IMR_INIT;
      m_initp = 1;
      m_pending.delete();
      m_pending.push_back(2);
      if (!m_sngl) m_pending.push_back(3);
      if (m_ic4) m_pending.push_back(4);
    end else if (ad) begin
      if (ready) m_imr = d;
      else if (m_init) begin
        kind = m_pending.pop_front();
        if (kind == 2) m_vb = d[7:8-VEC_W];
        else if (kind == 3) m_icw3 = d;
        else begin m_aeoi = d[1]; m_sfnm = d[4]; end
      end
    end else if (ready) begin
      if (!d[3]) begin
        m_r = d[7]; m_sl = d[6]; m_eoi = d[5]; m_lvl = d[2:0]; m_ocw2p = 1;
      end else begin
        if (d[1]) m_ris = d[0];
        if (d[6]) m_smm = d[5];
        m_pollp = d[2];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("seq_state", 32'(seq_state), 32'(m_state()));
    chk("init_done", 32'(init_done), 32'(m_state() == 3'd4));
    chk("init_pulse", 32'(init_pulse), 32'(m_initp));
    chk("ltim", 32'(ltim), 32'(m_ltim));
    chk("sngl", 32'(sngl), 32'(m_sngl));
    chk("vector_base", 32'(vector_base), 32'(m_vb));
    chk("icw3", 32'(icw3), 32'(m_icw3));
    chk("aeoi", 32'(aeoi), 32'(m_aeoi));
    chk("sfnm", 32'(sfnm), 32'(m_sfnm));
    chk("imr", 32'(imr), 32'(m_imr));
    chk("ocw2_pulse", 32'(ocw2_pulse), 32'(m_ocw2p));
    chk("ocw2_fields", 32'({ocw2_r, ocw2_sl, ocw2_eoi, ocw2_level}),
        32'({m_r, m_sl, m_eoi, m_lvl}));
    chk("smm", 32'(smm), 32'(m_smm));
    chk("ris", 32'(ris), 32'(m_ris));
    chk("poll_pulse", 32'(poll_pulse), 32'(m_pollp));
    chk("dout", 32'(dout), 32'(m_dout));
  endtask

  // Drive one cycle (inputs set #1 after the previous edge), then check #1 after this edge.
  task automatic step(input bit rst, input bit we, input bit ad, input logic [7:0] d);
    reset = rst; wr_strobe = we; a0 = ad; din = d;
    if (!hold_io) begin
      irr_in = 8'($urandom);
      isr_in = 8'($urandom);
    end
    model_apply(rst, we, ad, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] rd;
    bit         rw, ra;
    reset = 1'b1; wr_strobe = 1'b0; a0 = 1'b0; din = 8'h00; irr_in = 8'h00; isr_in = 8'h00;
    model_reset();

    // Reset state
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("rst_imr_const", 32'(imr), 32'(IMR_INIT));
    chk("rst_state_const", 32'(seq_state), 32'd0);

    // Single-mode init with ICW4
    step(0, 1, 0, 8'h13);
    chk("t1_state_w2", 32'(seq_state), 32'd1);
    chk("t1_init_pulse", 32'(init_pulse), 32'd1);
    step(0, 1, 1, 8'h48);
    chk("t1_state_w4", 32'(seq_state), 32'd3);
    chk("t1_pulse_gone", 32'(init_pulse), 32'd0);
    step(0, 1, 1, 8'h03);
    chk("t1_vb", 32'(vector_base), 32'h09);
    chk("t1_aeoi", 32'(aeoi), 32'd1);
    chk("t1_done", 32'(init_done), 32'd1);

    // Cascade init
    step(0, 1, 0, 8'h11);
    step(0, 1, 1, 8'h20);
    chk("t2_state_w3", 32'(seq_state), 32'd2);
    step(0, 1, 1, 8'h04);
    step(0, 1, 1, 8'h01);
    chk("t2_icw3", 32'(icw3), 32'h04);
    chk("t2_state", 32'(seq_state), 32'd4);

    // OCW1 then OCW2
    step(0, 1, 1, 8'hA5);
    chk("t3_imr", 32'(imr), 32'hA5);
    step(0, 1, 0, 8'h63);
    chk("t3_ocw2", 32'({ocw2_pulse, ocw2_r, ocw2_sl, ocw2_eoi, ocw2_level}), 32'b1_011_011);
    step(0, 0, 0, 8'h00);
    chk("t3_ocw2_once", 32'(ocw2_pulse), 32'd0);

    // OCW3 read select, poll, readback
    step(0, 1, 0, 8'h0B);
    chk("t4_ris", 32'(ris), 32'd1);
    step(0, 1, 0, 8'h0C);
    chk("t4_poll", 32'({poll_pulse, ris}), 32'b11);
    hold_io = 1'b1; isr_in = 8'h10; irr_in = 8'hEF;
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    hold_io = 1'b0;

    // Restart mid-sequence, OCW2 before READY, a0=1 in UNINIT
    step(0, 1, 0, 8'h11);
    step(0, 1, 1, 8'h20);
    step(0, 1, 1, 8'h77);
    step(0, 1, 0, 8'h11);
    chk("t5_restart", 32'({seq_state, icw3}), 32'({3'd1, 8'h00}));
    step(0, 1, 0, 8'h63);
    step(0, 1, 0, 8'h0C);
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'hFF);
    chk("t5_uninit_ignored", 32'({seq_state, imr}), 32'({3'd0, IMR_INIT}));

    // Reset colliding with an OCW1 in READY
    step(0, 1, 0, 8'h12);
    step(0, 1, 1, 8'hF8);
    step(1, 1, 1, 8'hC3);
    chk("t6_reset_wins", 32'({seq_state, imr}), 32'({3'd0, IMR_INIT}));

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rw = ($urandom_range(0, 3) != 0);
      ra = 1'($urandom);
      rd = 8'($urandom);
      if (!ra) rd[4] = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 79) == 0), rw, ra, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
